// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    // Arbiter FSM: grant in IDLE, hold the memory request in WAIT,
    // return a one-cycle completion in RESP.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Grant / owner encoding used by gnt and the round-robin pointer.
    localparam logic GNT_C = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (CPU = C, DMA = D), the arbiter
// and the memory model. The slave modport is the arbiter's view; the
// master modport is the view of whatever drives requests and memory
// responses (the surrounding system, or a testbench).
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    // CPU requester
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [DATA_W-1:0] c_rdata;
    logic              c_ready;
    logic              c_err;

    // DMA / loader requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              d_err;

    // Shared memory port
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ready;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_rdata, c_ready, c_err,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ready, d_err,
        output m_req, m_we, m_addr, m_wdata,
        input  m_rdata, m_ready
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_rdata, c_ready, c_err,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ready, d_err,
        input  m_req, m_we, m_addr, m_wdata,
        output m_rdata, m_ready
    );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational two-way round-robin chooser. A lone requester always
// wins; on a tie the requester that was not served last wins.
module rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] reqs,     // bit 0 = C, bit 1 = D
    input  logic       rr_last,  // owner of the previous grant
    output logic       winner,
    output logic       valid
);

    // Pick the winner from the request pair and the last owner
    always_comb begin
        valid  = |reqs;
        winner = GNT_C;
        case (reqs)
            2'b01:   winner = GNT_C;
            2'b10:   winner = GNT_D;
            2'b11:   winner = ~rr_last;
            default: winner = GNT_C;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter: registered round-robin grant, one
// outstanding transaction, and a WAIT timeout that returns an error
// completion so a requester never hangs on a dead memory.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus,
    output logic         gnt,
    output logic         busy
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    logic              rr_last_q, rr_last_d;
    logic              gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic              c_ready_q, c_ready_d;
    logic              c_err_q, c_err_d;
    logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
    logic              d_ready_q, d_ready_d;
    logic              d_err_q, d_err_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              pick_winner;
    logic              pick_valid;

    rr_pick u_rr_pick (
        .reqs    ({bus.d_req, bus.c_req}),
        .rr_last (rr_last_q),
        .winner  (pick_winner),
        .valid   (pick_valid)
    );

    // Next state and next registered outputs of the arbitration FSM
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        // Completion outputs are pulses; they fall back to zero unless set below.
        c_ready_d = 1'b0;
        c_err_d   = 1'b0;
        c_rdata_d = '0;
        d_ready_d = 1'b0;
        d_err_d   = 1'b0;
        d_rdata_d = '0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d   = WAIT;
                    gnt_d     = pick_winner;
                    rr_last_d = pick_winner;
                    cnt_d     = '0;
                    if (pick_winner == GNT_D) begin
                        m_we_d    = bus.d_we;
                        m_addr_d  = bus.d_addr;
                        m_wdata_d = bus.d_wdata;
                    end else begin
                        m_we_d    = bus.c_we;
                        m_addr_d  = bus.c_addr;
                        m_wdata_d = bus.c_wdata;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (bus.m_ready) begin
                    // Memory answered: hand its data to the owner (also for writes).
                    state_d = RESP;
                    if (gnt_q == GNT_D) begin
                        d_ready_d = 1'b1;
                        d_rdata_d = bus.m_rdata;
                    end else begin
                        c_ready_d = 1'b1;
                        c_rdata_d = bus.m_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Give up on the memory: error completion with zero data.
                    state_d = RESP;
                    if (gnt_q == GNT_D) begin
                        d_ready_d = 1'b1;
                        d_err_d   = 1'b1;
                    end else begin
                        c_ready_d = 1'b1;
                        c_err_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                // Requests are not looked at while the completion is visible.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        m_req_d = (state_d == WAIT);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_last_q <= GNT_D;
            gnt_q     <= GNT_C;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            c_ready_q <= 1'b0;
            c_err_q   <= 1'b0;
            c_rdata_q <= '0;
            d_ready_q <= 1'b0;
            d_err_q   <= 1'b0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            c_ready_q <= c_ready_d;
            c_err_q   <= c_err_d;
            c_rdata_q <= c_rdata_d;
            d_ready_q <= d_ready_d;
            d_err_q   <= d_err_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.c_ready = c_ready_q;
    assign bus.c_err   = c_err_q;
    assign bus.c_rdata = c_rdata_q;
    assign bus.d_ready = d_ready_q;
    assign bus.d_err   = d_err_q;
    assign bus.d_rdata = d_rdata_q;
    assign gnt         = gnt_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized two-port
// traffic, checked against a transaction-level model of the arbiter.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct { logic we; logic [7:0] addr; logic [7:0] wdata; } op_t;
    typedef struct { logic port; logic err; logic [7:0] rdata; logic gnt; } cpl_t;

    logic clk;
    logic rst;
    logic gnt;
    logic busy;

    mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(15)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .gnt  (gnt),
        .busy (busy)
    );

    int         n_pass  = 0;
    int         n_total = 0;
    int         n_fail  = 0;
    logic [7:0] mem     [256];   // memory seen by the DUT
    logic [7:0] ref_mem [256];   // model's copy of the memory
    op_t        c_ops[$];
    op_t        d_ops[$];
    cpl_t       cpl_log[$];
    cpl_t       exp_cpl[$];
    op_t        mem_log[$];
    op_t        exp_mem[$];
    int         mreq_rise[$];
    int         cready_cyc[$];
    int         mem_lat;
    bit         lat_rand;
    int         last_run;
    int         cyc;
    logic       m_rr_last;

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic op_t mk_op(input logic we, input logic [7:0] a, input logic [7:0] w);
        op_t o;
        o.we = we; o.addr = a; o.wdata = w;
        return o;
    endfunction

    // Memory model: answers after mem_lat cycles of m_req; addresses >= 0xF0 never answer
    initial begin : responder
        int  wait_cnt;
        int  cur_lat;
        op_t acc;
        wait_cnt     = 0;
        cur_lat      = 1;
        last_run     = 0;
        bus.m_ready  = 1'b0;
        bus.m_rdata  = 8'h00;
        forever begin
            @(negedge clk);
            bus.m_ready = 1'b0;
            bus.m_rdata = 8'($urandom);
            if (bus.m_req === 1'b1) begin
                if (wait_cnt == 0) cur_lat = lat_rand ? int'($urandom_range(5, 1)) : mem_lat;
                wait_cnt++;
                if (bus.m_addr < 8'hF0 && wait_cnt == cur_lat) begin
                    bus.m_ready = 1'b1;
                    bus.m_rdata = mem[bus.m_addr];
                    if (bus.m_we === 1'b1) mem[bus.m_addr] = bus.m_wdata;
                    acc.we = bus.m_we; acc.addr = bus.m_addr; acc.wdata = bus.m_wdata;
                    mem_log.push_back(acc);
                end
            end else begin
                if (wait_cnt != 0) last_run = wait_cnt;
                wait_cnt = 0;
            end
        end
    end

    // Completion monitor
    initial begin : monitor
        logic prev_mreq;
        cpl_t e;
        prev_mreq = 1'b0;
        cyc       = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.m_req === 1'b1 && prev_mreq !== 1'b1) mreq_rise.push_back(cyc);
            prev_mreq = bus.m_req;
            if (bus.c_ready === 1'b1) begin
                check("D quiet at C ready", 32'({bus.d_ready, bus.d_err, bus.d_rdata}), 32'd0);
                e.port = GNT_C; e.err = bus.c_err; e.rdata = bus.c_rdata; e.gnt = gnt;
                cpl_log.push_back(e);
                cready_cyc.push_back(cyc);
            end
            if (bus.d_ready === 1'b1) begin
                check("C quiet at D ready", 32'({bus.c_ready, bus.c_err, bus.c_rdata}), 32'd0);
                e.port = GNT_D; e.err = bus.d_err; e.rdata = bus.d_rdata; e.gnt = gnt;
                cpl_log.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        cpl_log.delete(); exp_cpl.delete(); mem_log.delete(); exp_mem.delete();
        mreq_rise.delete(); cready_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.c_req = 1'b0; bus.d_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        m_rr_last = GNT_D;
        clear_logs();
    endtask

    // Transaction-level model: while both ports have work they alternate,
    // starting with the port that was not served last; a dead address
    // completes with err=1 and rdata=0 and never touches memory.
    task automatic predict();
        int   i;
        int   j;
        logic port;
        op_t  op;
        cpl_t e;
        i = 0; j = 0;
        while (i < c_ops.size() || j < d_ops.size()) begin
            if (i < c_ops.size() && j < d_ops.size()) port = ~m_rr_last;
            else port = (i < c_ops.size()) ? GNT_C : GNT_D;
            if (port == GNT_C) begin op = c_ops[i]; i++; end
            else begin op = d_ops[j]; j++; end
            m_rr_last = port;
            e.port = port; e.gnt = port;
            if (op.addr >= 8'hF0) begin
                e.err = 1'b1; e.rdata = 8'h00;
            end else begin
                e.err = 1'b0; e.rdata = ref_mem[op.addr];
                if (op.we) ref_mem[op.addr] = op.wdata;
                exp_mem.push_back(op);
            end
            exp_cpl.push_back(e);
        end
    endtask

    // Requester driver: holds req with stable fields until ready, next op the cycle after
    task automatic run_port(input logic port);
        op_t op;
        bit  got;
        int  waited;
        while ((port == GNT_C) ? (c_ops.size() != 0) : (d_ops.size() != 0)) begin
            if (port == GNT_C) begin
                op = c_ops.pop_front();
                bus.c_req = 1'b1; bus.c_we = op.we; bus.c_addr = op.addr; bus.c_wdata = op.wdata;
            end else begin
                op = d_ops.pop_front();
                bus.d_req = 1'b1; bus.d_we = op.we; bus.d_addr = op.addr; bus.d_wdata = op.wdata;
            end
            got = 1'b0; waited = 0;
            while (!got && waited < 200) begin
                @(negedge clk);
                waited++;
                got = (port == GNT_C) ? (bus.c_ready === 1'b1) : (bus.d_ready === 1'b1);
            end
            check((port == GNT_C) ? "C ready arrives" : "D ready arrives", 32'(got), 32'd1);
            tick();
            if (!got) begin
                if (port == GNT_C) c_ops.delete(); else d_ops.delete();
            end
        end
        if (port == GNT_C) bus.c_req = 1'b0; else bus.d_req = 1'b0;
    endtask

    task automatic run_ops();
        predict();
        fork
            run_port(GNT_C);
            run_port(GNT_D);
        join
        tick();
        tick();
    endtask

    task automatic compare_logs(input string tag);
        check($sformatf("%s completions", tag), 32'(cpl_log.size()), 32'(exp_cpl.size()));
        for (int k = 0; k < exp_cpl.size() && k < cpl_log.size(); k++) begin
            check($sformatf("%s cpl%0d port", tag, k), 32'(cpl_log[k].port), 32'(exp_cpl[k].port));
            check($sformatf("%s cpl%0d err", tag, k), 32'(cpl_log[k].err), 32'(exp_cpl[k].err));
            check($sformatf("%s cpl%0d rdata", tag, k), 32'(cpl_log[k].rdata), 32'(exp_cpl[k].rdata));
            check($sformatf("%s cpl%0d gnt", tag, k), 32'(cpl_log[k].gnt), 32'(exp_cpl[k].gnt));
        end
        check($sformatf("%s mem accesses", tag), 32'(mem_log.size()), 32'(exp_mem.size()));
        for (int k = 0; k < exp_mem.size() && k < mem_log.size(); k++) begin
            check($sformatf("%s acc%0d we", tag, k), 32'(mem_log[k].we), 32'(exp_mem[k].we));
            check($sformatf("%s acc%0d addr", tag, k), 32'(mem_log[k].addr), 32'(exp_mem[k].addr));
            if (exp_mem[k].we)
                check($sformatf("%s acc%0d wdata", tag, k), 32'(mem_log[k].wdata), 32'(exp_mem[k].wdata));
        end
        clear_logs();
    endtask

    function automatic op_t rand_op(input bit allow_dead);
        logic [7:0] a;
        if (allow_dead && $urandom_range(7, 0) == 0) a = 8'(240 + $urandom_range(15, 0));
        else a = 8'($urandom_range(239, 0));
        return mk_op(1'($urandom_range(1, 0)), a, 8'($urandom));
    endfunction

    initial begin : main
        int nc;
        int nd;
        rst = 1'b1;
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = 8'h00; bus.c_wdata = 8'h00;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 8'h00; bus.d_wdata = 8'h00;
        mem_lat = 2; lat_rand = 1'b0; m_rr_last = GNT_D;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i * 7 + 3);
            ref_mem[i] = mem[i];
        end
        tick();
        do_reset();

        // Reset values
        @(negedge clk);
        check("reset m_req/m_we", 32'({bus.m_req, bus.m_we}), 32'd0);
        check("reset m_addr/m_wdata", 32'({bus.m_addr, bus.m_wdata}), 32'd0);
        check("reset C outputs", 32'({bus.c_ready, bus.c_err, bus.c_rdata}), 32'd0);
        check("reset D outputs", 32'({bus.d_ready, bus.d_err, bus.d_rdata}), 32'd0);
        check("reset gnt/busy", 32'({gnt, busy}), 32'd0);
        tick();

        // Single C read of 0x10, memory answers after 2 cycles
        mem[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5; mem_lat = 2;
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 8'h10; bus.c_wdata = 8'h77;
        @(negedge clk);
        check("t1 m_req before grant edge", 32'(bus.m_req), 32'd0);
        @(negedge clk);
        check("t1 m_req after grant edge", 32'(bus.m_req), 32'd1);
        check("t1 m_addr", 32'(bus.m_addr), 32'h10);
        check("t1 m_we", 32'(bus.m_we), 32'd0);
        check("t1 gnt/busy", 32'({gnt, busy}), 32'b01);
        @(negedge clk);
        check("t1 c_ready while waiting", 32'(bus.c_ready), 32'd0);
        @(negedge clk);
        check("t1 c_ready", 32'(bus.c_ready), 32'd1);
        check("t1 c_rdata", 32'(bus.c_rdata), 32'hA5);
        check("t1 c_err", 32'(bus.c_err), 32'd0);
        check("t1 d_ready", 32'(bus.d_ready), 32'd0);
        check("t1 m_req in resp", 32'(bus.m_req), 32'd0);
        tick();
        bus.c_req = 1'b0;
        @(negedge clk);
        check("t1 ready is one pulse", 32'({bus.c_ready, busy}), 32'd0);
        check("t1 completions", 32'(cpl_log.size()), 32'd1);
        tick();

        // Simultaneous C and D writes after reset: C first, then D
        do_reset();
        mem_lat = 2;
        c_ops.push_back(mk_op(1'b1, 8'h20, 8'h11));
        d_ops.push_back(mk_op(1'b1, 8'h30, 8'h22));
        run_ops();
        if (mem_log.size() == 2) begin
            check("t2 first write addr", 32'(mem_log[0].addr), 32'h20);
            check("t2 second write addr", 32'(mem_log[1].addr), 32'h30);
        end
        compare_logs("t2");

        // Continuous contention: 3 ops per port, grants alternate C,D,...
        do_reset();
        lat_rand = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c_ops.push_back(rand_op(1'b0));
            d_ops.push_back(rand_op(1'b0));
        end
        run_ops();
        nc = 0; nd = 0;
        foreach (cpl_log[k]) begin
            if (cpl_log[k].port == GNT_C) nc++; else nd++;
        end
        check("t3 C ready count", 32'(nc), 32'd3);
        check("t3 D ready count", 32'(nd), 32'd3);
        compare_logs("t3");

        // Timeout on a dead address, then a normal C read
        lat_rand = 1'b0; mem_lat = 3;
        d_ops.push_back(mk_op(1'b0, 8'hF5, 8'h00));
        run_ops();
        check("t4 m_req cycles before timeout", 32'(last_run), 32'd15);
        compare_logs("t4 timeout");
        c_ops.push_back(mk_op(1'b0, 8'h44, 8'h00));
        run_ops();
        compare_logs("t4 after timeout");

        // Reset while a C read is in WAIT
        do_reset();
        mem_lat = 8;
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 8'h50; bus.c_wdata = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check("t5 m_req before reset", 32'(bus.m_req), 32'd1);
        tick();
        rst = 1'b1; bus.c_req = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        m_rr_last = GNT_D;
        @(negedge clk);
        check("t5 m_req after reset", 32'(bus.m_req), 32'd0);
        check("t5 outputs after reset", 32'({bus.c_ready, bus.c_err, bus.d_ready, busy}), 32'd0);
        repeat (10) @(negedge clk);
        check("t5 no completion for dropped read", 32'(cpl_log.size()), 32'd0);
        check("t5 no memory access", 32'(mem_log.size()), 32'd0);
        clear_logs();
        tick();
        mem_lat = 2;
        d_ops.push_back(mk_op(1'b0, 8'h60, 8'h00));
        run_ops();
        compare_logs("t5 D read");
        c_ops.push_back(mk_op(1'b0, 8'h61, 8'h00));
        d_ops.push_back(mk_op(1'b0, 8'h62, 8'h00));
        run_ops();
        if (cpl_log.size() > 0) check("t5 tie winner", 32'(cpl_log[0].port), 32'(GNT_C));
        compare_logs("t5 tie");

        // Back-to-back C reads with req held
        do_reset();
        mem_lat = 1;
        c_ops.push_back(mk_op(1'b0, 8'h01, 8'h00));
        c_ops.push_back(mk_op(1'b0, 8'h02, 8'h00));
        run_ops();
        check("t6 m_req rises", 32'(mreq_rise.size()), 32'd2);
        if (mreq_rise.size() >= 2 && cready_cyc.size() >= 1)
            check("t6 second m_req after first ready", 32'(mreq_rise[1] - cready_cyc[0]), 32'd2);
        compare_logs("t6");

        // Randomized traffic on both ports, random memory latency, some dead addresses
        lat_rand = 1'b1;
        for (int r = 0; r < 10; r++) begin
            nc = int'($urandom_range(5, 0));
            nd = int'($urandom_range(5, 0));
            for (int i = 0; i < nc; i++) c_ops.push_back(rand_op(1'b1));
            for (int i = 0; i < nd; i++) d_ops.push_back(rand_op(1'b1));
            run_ops();
            compare_logs($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
